// File: rtl/lcd_pkg.sv
// Shared constants, rectangle layout and FSM states for the LCD window
// arbiter.
package lcd_pkg;

    localparam int COORD_W = 9;
    localparam int RECT_W  = 4 * COORD_W;

    localparam int DEF_PANEL_W    = 240;
    localparam int DEF_PANEL_H    = 135;
    localparam int DEF_COL_OFFSET = 40;
    localparam int DEF_ROW_OFFSET = 53;

    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_RASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } rect_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CASET,
        RASET,
        RAMWR,
        PIX_HI,
        PIX_LO,
        DONE
    } state_t;

    // idx 1..4 selects start hi/lo, end hi/lo of the offset window
    function automatic logic [7:0] addr_byte(
        input logic [2:0] idx,
        input coord_t     lo,
        input coord_t     hi,
        input int         off
    );
        logic [15:0] s;
        logic [15:0] e;
        s = 16'(lo) + 16'(off);
        e = 16'(hi) + 16'(off);
        unique case (idx)
            3'd1:    addr_byte = s[15:8];
            3'd2:    addr_byte = s[7:0];
            3'd3:    addr_byte = e[15:8];
            default: addr_byte = e[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lcd_window_arbiter_if.sv
// Requester, pixel and byte-link signals of the LCD window arbiter.
interface lcd_window_arbiter_if;
    import lcd_pkg::*;

    logic                init_done;
    logic [1:0]          req_valid;
    logic [2*RECT_W-1:0] req_rect;
    logic [1:0]          req_ready;
    logic [1:0]          req_err;
    logic [1:0]          grant;
    logic [31:0]         pix_data;
    logic [1:0]          pix_valid;
    logic [1:0]          pix_ready;
    logic [7:0]          byte_data;
    logic                byte_dc;
    logic                byte_valid;
    logic                byte_ready;
    logic                busy;

    modport slave (
        input  init_done, req_valid, req_rect,
        input  pix_data, pix_valid, byte_ready,
        output req_ready, req_err, grant, pix_ready,
        output byte_data, byte_dc, byte_valid, busy
    );

    modport master (
        output init_done, req_valid, req_rect,
        output pix_data, pix_valid, byte_ready,
        input  req_ready, req_err, grant, pix_ready,
        input  byte_data, byte_dc, byte_valid, busy
    );

endinterface

// File: rtl/lcd_rr_arb.sv
// Two-way requester arbiter; round-robin when LCD_ARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority to requester 0.
module lcd_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // ptr high means requester 1 is favoured on contention
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!ptr || !req[1]))
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (take) begin
`ifdef LCD_ARB_ROUND_ROBIN_EN
            ptr <= gnt[0];
`else
            ptr <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/lcd_window_arbiter.sv
// Grants one of two requesters the LCD byte link and streams a window:
// CASET, RASET, RAMWR then RGB565 pixels. Policy set by LCD_ARB_ROUND_ROBIN_EN.
module lcd_window_arbiter
    import lcd_pkg::*;
#(
    parameter int PANEL_W    = DEF_PANEL_W,
    parameter int PANEL_H    = DEF_PANEL_H,
    parameter int COL_OFFSET = DEF_COL_OFFSET,
    parameter int ROW_OFFSET = DEF_ROW_OFFSET
) (
    input logic                 clk,
    input logic                 reset,
    lcd_window_arbiter_if.slave lcd
);

    state_t      state;
    rect_t       rect;
    logic [1:0]  grant_q;
    logic [1:0]  rdy_q;
    logic [1:0]  err_q;
    logic        busy_q;
    logic        bv_q;
    logic        bdc_q;
    logic [7:0]  bd_q;
    logic [7:0]  pix_lo_q;
    logic [2:0]  idx;
    logic [15:0] cnt;

    logic [1:0]  arb_gnt;
    logic        take;
    logic        can_load;
    logic        bad;
    logic        pix_hs;
    logic [1:0]  pix_rdy;
    logic [15:0] pix;
    logic [15:0] npix;
    logic [7:0]  seq_byte;
    rect_t       sel_rect;

    lcd_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (lcd.req_valid),
        .take  (take),
        .gnt   (arb_gnt)
    );

    always_comb begin
        can_load = !bv_q || lcd.byte_ready;
        // hold off one cycle after a reject so the requester can drop
        take = (state == IDLE) && lcd.init_done
            && (|lcd.req_valid) && !(|rdy_q);
        sel_rect = arb_gnt[1]
            ? rect_t'(lcd.req_rect[2*RECT_W-1:RECT_W])
            : rect_t'(lcd.req_rect[RECT_W-1:0]);
        bad = (rect.x1 < rect.x0) || (rect.y1 < rect.y0)
            || (32'(rect.x1) >= PANEL_W)
            || (32'(rect.y1) >= PANEL_H);
        npix = (16'(rect.x1) - 16'(rect.x0) + 16'd1)
             * (16'(rect.y1) - 16'(rect.y0) + 16'd1);
        pix_rdy = (state == PIX_HI && can_load) ? grant_q : 2'b00;
        pix_hs = |(lcd.pix_valid & pix_rdy);
        pix = grant_q[1] ? lcd.pix_data[31:16] : lcd.pix_data[15:0];
        seq_byte = (state == CASET)
            ? addr_byte(idx, rect.x0, rect.x1, COL_OFFSET)
            : addr_byte(idx, rect.y0, rect.y1, ROW_OFFSET);
        if (idx == 3'd0)
            seq_byte = (state == CASET) ? OP_CASET : OP_RASET;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rect     <= '0;
            grant_q  <= 2'b00;
            rdy_q    <= 2'b00;
            err_q    <= 2'b00;
            busy_q   <= 1'b0;
            bv_q     <= 1'b0;
            bdc_q    <= 1'b0;
            bd_q     <= 8'h00;
            pix_lo_q <= 8'h00;
            idx      <= 3'd0;
            cnt      <= 16'd0;
        end else begin
            rdy_q <= 2'b00;
            err_q <= 2'b00;
            if (bv_q && lcd.byte_ready)
                bv_q <= 1'b0;
            unique case (state)
                IDLE: if (take) begin
                    grant_q <= arb_gnt;
                    busy_q  <= 1'b1;
                    rect    <= sel_rect;
                    state   <= CHECK;
                end
                CHECK: begin
                    rdy_q <= grant_q;
                    idx   <= 3'd0;
                    if (bad) begin
                        err_q   <= grant_q;
                        grant_q <= 2'b00;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= CASET;
                    end
                end
                CASET, RASET: if (can_load) begin
                    bv_q  <= 1'b1;
                    bdc_q <= (idx != 3'd0);
                    bd_q  <= seq_byte;
                    idx   <= idx + 3'd1;
                    if (idx == 3'd4) begin
                        idx   <= 3'd0;
                        state <= (state == CASET) ? RASET : RAMWR;
                    end
                end
                RAMWR: if (can_load) begin
                    bv_q  <= 1'b1;
                    bdc_q <= 1'b0;
                    bd_q  <= OP_RAMWR;
                    cnt   <= npix;
                    state <= PIX_HI;
                end
                PIX_HI: if (pix_hs) begin
                    bv_q     <= 1'b1;
                    bdc_q    <= 1'b1;
                    bd_q     <= pix[15:8];
                    pix_lo_q <= pix[7:0];
                    state    <= PIX_LO;
                end
                PIX_LO: if (can_load) begin
                    bv_q  <= 1'b1;
                    bdc_q <= 1'b1;
                    bd_q  <= pix_lo_q;
                    cnt   <= cnt - 16'd1;
                    state <= (cnt == 16'd1) ? DONE : PIX_HI;
                end
                DONE: if (can_load) begin
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lcd.req_ready  = rdy_q;
    assign lcd.req_err    = err_q;
    assign lcd.grant      = grant_q;
    assign lcd.pix_ready  = pix_rdy;
    assign lcd.byte_data  = bd_q;
    assign lcd.byte_dc    = bdc_q;
    assign lcd.byte_valid = bv_q;
    assign lcd.busy       = busy_q;

endmodule

// File: tb/tb_lcd_window_arbiter.sv
// Scoreboard bench for lcd_window_arbiter: a rectangle-level model predicts
// grants, accept/reject pulses and the byte stream of every request.
module tb_lcd_window_arbiter;
    import lcd_pkg::*;

    localparam int PW = 240;
    localparam int PH = 135;
    localparam int CO = 40;
    localparam int RO = 53;
`ifdef LCD_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_window_arbiter_if lcd ();

    lcd_window_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .lcd   (lcd)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int nbytes   = 0;
    int last_srv = 1;
    int br_mode  = 1;
    bit pv_always = 1'b1;

    logic [8:0]  expq[$];
    logic [3:0]  respq[$];
    int          expg[$];
    logic [15:0] pixq0[$];
    logic [15:0] pixq1[$];
    logic [35:0] reqq0[$];
    logic [35:0] reqq1[$];
    logic [35:0] bq0[$];
    logic [35:0] bq1[$];

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [35:0] mk(int x0, int y0, int x1, int y1);
        return {9'(x0), 9'(y0), 9'(x1), 9'(y1)};
    endfunction

    function automatic void push_word(int v);
        expq.push_back({1'b1, 8'((v >> 8) & 255)});
        expq.push_back({1'b1, 8'(v & 255)});
    endfunction

    // expected behaviour of one granted request
    function automatic void model_txn(int r, logic [35:0] rc);
        int x0 = int'(rc[35:27]);
        int y0 = int'(rc[26:18]);
        int x1 = int'(rc[17:9]);
        int y1 = int'(rc[8:0]);
        logic [1:0] m = (r == 0) ? 2'b01 : 2'b10;
        logic [15:0] p;
        expg.push_back(r);
        if (x1 < x0 || y1 < y0 || x1 >= PW || y1 >= PH) begin
            respq.push_back({m, m});
            return;
        end
        respq.push_back({m, 2'b00});
        expq.push_back({1'b0, 8'h2A});
        push_word(x0 + CO);
        push_word(x1 + CO);
        expq.push_back({1'b0, 8'h2B});
        push_word(y0 + RO);
        push_word(y1 + RO);
        expq.push_back({1'b0, 8'h2C});
        for (int k = 0; k < (x1 - x0 + 1) * (y1 - y0 + 1); k++) begin
            p = 16'($urandom);
            if (r == 0) pixq0.push_back(p);
            else pixq1.push_back(p);
            expq.push_back({1'b1, p[15:8]});
            expq.push_back({1'b1, p[7:0]});
        end
    endfunction

    task automatic stage_batch();
        int i0 = 0;
        int i1 = 0;
        int r;
        while (i0 < bq0.size() || i1 < bq1.size()) begin
            if (i0 < bq0.size() && i1 < bq1.size())
                r = (RR && last_srv == 0) ? 1 : 0;
            else
                r = (i0 < bq0.size()) ? 0 : 1;
            last_srv = r;
            if (r == 0) begin
                model_txn(0, bq0[i0]);
                i0++;
            end else begin
                model_txn(1, bq1[i1]);
                i1++;
            end
        end
        foreach (bq0[k]) reqq0.push_back(bq0[k]);
        foreach (bq1[k]) reqq1.push_back(bq1[k]);
        bq0.delete();
        bq1.delete();
    endtask

    task automatic flush_all();
        expq.delete();
        respq.delete();
        expg.delete();
        pixq0.delete();
        pixq1.delete();
        reqq0.delete();
        reqq1.delete();
    endtask

    task automatic wait_done(int budget);
        int c = 0;
        while ((expq.size() != 0 || respq.size() != 0
                || expg.size() != 0 || reqq0.size() != 0
                || reqq1.size() != 0 || lcd.busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL txn_timeout: bytes left %0d want 0",
                     expq.size());
            flush_all();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_batch(int budget);
        stage_batch();
        wait_done(budget);
    endtask

    task automatic chk_reset_outputs(string tag);
        check({tag, "_grant"}, lcd.grant, 0);
        check({tag, "_busy"}, lcd.busy, 0);
        check({tag, "_req_ready"}, lcd.req_ready, 0);
        check({tag, "_req_err"}, lcd.req_err, 0);
        check({tag, "_pix_ready"}, lcd.pix_ready, 0);
        check({tag, "_byte_valid"}, lcd.byte_valid, 0);
        check({tag, "_byte_dc"}, lcd.byte_dc, 0);
        check({tag, "_byte_data"}, lcd.byte_data, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_all();
        last_srv = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // requesters, pixel sources and serializer backpressure
    initial begin : drivers
        logic [1:0] acc;
        logic [1:0] hs;
        lcd.req_valid  = 2'b00;
        lcd.req_rect   = '0;
        lcd.pix_valid  = 2'b00;
        lcd.pix_data   = '0;
        lcd.byte_ready = 1'b0;
        forever begin
            @(negedge clk);
            acc = lcd.req_ready;
            hs  = lcd.pix_valid & lcd.pix_ready;
            @(posedge clk);
            #1;
            if (acc[0] && reqq0.size() != 0) void'(reqq0.pop_front());
            if (acc[1] && reqq1.size() != 0) void'(reqq1.pop_front());
            if (hs[0] && pixq0.size() != 0) void'(pixq0.pop_front());
            if (hs[1] && pixq1.size() != 0) void'(pixq1.pop_front());
            lcd.req_valid = {reqq1.size() != 0, reqq0.size() != 0};
            lcd.req_rect = {(reqq1.size() != 0) ? reqq1[0] : 36'h0,
                            (reqq0.size() != 0) ? reqq0[0] : 36'h0};
            lcd.pix_valid[0] = pixq0.size() != 0
                && (pv_always || $urandom_range(3) != 0);
            lcd.pix_valid[1] = pixq1.size() != 0
                && (pv_always || $urandom_range(3) != 0);
            lcd.pix_data = {(pixq1.size() != 0) ? pixq1[0] : 16'h0,
                            (pixq0.size() != 0) ? pixq0[0] : 16'h0};
            lcd.byte_ready = (br_mode == 1) ? 1'b1
                : (br_mode == 2) ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    initial begin : monitor
        logic [1:0] gprev = 2'b00;
        int g;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (lcd.byte_valid && lcd.byte_ready) begin
                    nbytes++;
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_byte: got %0h want none",
                                 {lcd.byte_dc, lcd.byte_data});
                    end else begin
                        check("byte", {lcd.byte_dc, lcd.byte_data},
                              expq.pop_front());
                    end
                end
                if ((lcd.req_ready | lcd.req_err) != 2'b00) begin
                    if (respq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_resp: got %0h want none",
                                 {lcd.req_ready, lcd.req_err});
                    end else begin
                        check("resp", {lcd.req_ready, lcd.req_err},
                              respq.pop_front());
                    end
                end
                if (lcd.grant != 2'b00 && gprev == 2'b00) begin
                    if (expg.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_grant: got %0h want none",
                                 lcd.grant);
                    end else begin
                        g = expg.pop_front();
                        check("grant", lcd.grant, (g == 0) ? 1 : 2);
                    end
                end
                if (lcd.pix_ready != 2'b00)
                    check("pix_ready_owner", lcd.pix_ready & ~lcd.grant, 0);
            end
            gprev = lcd.grant;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        int c;
        logic [7:0] hd;
        logic hdc;
        int x0, y0, x1, y1, t;

        reset = 1'b1;
        lcd.init_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // no grant while the panel is still initialising
        bq0.push_back(mk(0, 0, 1, 0));
        stage_batch();
        repeat (20) @(negedge clk);
        check("no_grant_before_init", lcd.grant, 0);
        check("no_busy_before_init", lcd.busy, 0);
        lcd.init_done = 1'b1;
        wait_done(200);

        // rejected rectangle: no bytes at all
        n0 = nbytes;
        bq1.push_back(mk(5, 5, 4, 5));
        run_batch(100);
        check("reject_bytes", nbytes - n0, 0);

        // edge of the panel, mixed accept/reject under contention
        bq0.push_back(mk(0, 0, 240, 0));
        bq0.push_back(mk(239, 134, 239, 134));
        bq1.push_back(mk(0, 0, 0, 135));
        bq1.push_back(mk(238, 0, 239, 1));
        run_batch(500);

        // requester 0 re-requests while 1 is still waiting
        do_reset();
        bq0.push_back(mk(1, 2, 2, 2));
        bq0.push_back(mk(7, 7, 7, 8));
        bq1.push_back(mk(3, 3, 4, 3));
        run_batch(600);

        // serializer stall inside the address phase
        n0 = nbytes;
        bq0.push_back(mk(3, 4, 5, 6));
        stage_batch();
        c = 0;
        while (nbytes < n0 + 2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        br_mode = 2;
        @(negedge clk);
        hd  = lcd.byte_data;
        hdc = lcd.byte_dc;
        check("stall_valid", lcd.byte_valid, 1);
        repeat (9) begin
            @(negedge clk);
            check("stall_data", lcd.byte_data, hd);
            check("stall_dc", lcd.byte_dc, hdc);
            check("stall_valid", lcd.byte_valid, 1);
        end
        br_mode = 1;
        wait_done(300);

        // random traffic with backpressure and bursty pixels
        br_mode = 0;
        pv_always = 1'b0;
        repeat (10) begin
            repeat (2) begin
                for (int r = 0; r < 2; r++) begin
                    if ($urandom_range(2) != 0) begin
                        x0 = $urandom_range(0, 239);
                        x1 = x0 + $urandom_range(0, 3);
                        y0 = $urandom_range(0, 134);
                        y1 = y0 + $urandom_range(0, 2);
                        if ($urandom_range(7) == 0) begin
                            t = x0; x0 = x1; x1 = t;
                        end
                        if (r == 0) bq0.push_back(mk(x0, y0, x1, y1));
                        else bq1.push_back(mk(x0, y0, x1, y1));
                    end
                end
            end
            run_batch(3000);
        end

        // full screen; init_done falls mid-transfer without effect
        br_mode = 1;
        pv_always = 1'b1;
        n0 = nbytes;
        bq0.push_back(mk(0, 0, 239, 134));
        stage_batch();
        repeat (200) @(negedge clk);
        check("full_busy_mid", lcd.busy, 1);
        lcd.init_done = 1'b0;
        wait_done(70000);
        lcd.init_done = 1'b1;
        check("full_bytes", nbytes - n0, 11 + 64800);
        check("full_busy_end", lcd.busy, 0);

        // reset while streaming pixel low bytes
        bq1.push_back(mk(10, 10, 19, 19));
        stage_batch();
        c = 0;
        while (dut.state != PIX_LO && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("reached_pix_lo", c < 300, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        flush_all();
        last_srv = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n0 = nbytes;
        repeat (30) @(negedge clk);
        check("post_reset_bytes", nbytes - n0, 0);
        check("post_reset_grant", lcd.grant, 0);
        check("post_reset_busy", lcd.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
